// File: rtl/rename_free_list_if.sv
// Rename/retire <-> free-list bundle: two allocation slots out, two release slots in.
// The master side is rename/retire; the slave side is the free list.
interface rename_free_list_if #(
  parameter int NUM_P_REGS = 64
);
  localparam int PW = $clog2(NUM_P_REGS);

  logic          alloc0_req_i;
  logic          alloc1_req_i;
  logic [PW-1:0] alloc_dest0_o;
  logic [PW-1:0] alloc_dest1_o;
  logic          alloc_stall_o;
  logic          free0_en_i;
  logic [PW-1:0] free0_reg_i;
  logic          free1_en_i;
  logic [PW-1:0] free1_reg_i;
  logic [PW:0]   free_count_o;
  logic          error_o;

  modport master (
    output alloc0_req_i, alloc1_req_i,
    output free0_en_i, free0_reg_i, free1_en_i, free1_reg_i,
    input  alloc_dest0_o, alloc_dest1_o, alloc_stall_o, free_count_o, error_o
  );

  modport slave (
    input  alloc0_req_i, alloc1_req_i,
    input  free0_en_i, free0_reg_i, free1_en_i, free1_reg_i,
    output alloc_dest0_o, alloc_dest1_o, alloc_stall_o, free_count_o, error_o
  );
endinterface

// File: rtl/rename_free_list.sv
// Physical-register free list: circular FIFO, 2 allocs (0-cycle tag lookup, pop at edge) + 2 releases per cycle.
// alloc_stall_o (count<2) blocks all allocation; FREE_LIST_CHECK_EN adds double-free detection.
module rename_free_list #(
  parameter int NUM_P_REGS = 64,
  parameter int NUM_A_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  rename_free_list_if.slave fl
);
  localparam int          PW        = $clog2(NUM_P_REGS);
  localparam int          INIT_FREE = NUM_P_REGS - NUM_A_REGS;
  localparam logic [PW:0] DEPTH     = (PW+1)'(NUM_P_REGS);

  logic [PW-1:0] fifo_q [NUM_P_REGS];
  logic [PW-1:0] fifo_d [NUM_P_REGS];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          error_q, error_d;

  logic          stall;
  logic [1:0]    n_alloc;
  logic [PW-1:0] head_p1, tail_p1;
  logic [PW:0]   occ_pop, occ0;
  logic          acc0, acc1, err0, err1;
  logic          dup0, dup1;

  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  assign fl.alloc_dest0_o = fifo_q[head_q];
  assign fl.alloc_dest1_o = fl.alloc0_req_i ? fifo_q[head_p1] : fifo_q[head_q];
  assign fl.alloc_stall_o = stall;
  assign fl.free_count_o  = count_q;
  assign fl.error_o       = error_q;

  always_comb begin
    stall   = count_q < (PW+1)'(2);
    n_alloc = stall ? 2'd0 : 2'(fl.alloc0_req_i) + 2'(fl.alloc1_req_i);
    // Fullness is judged after this cycle's pops, so a release can reuse a slot freed by an allocation.
    occ_pop = count_q - (PW+1)'(n_alloc);

    acc0 = 1'b0;
    err0 = 1'b0;
    if (fl.free0_en_i && (fl.free0_reg_i != '0)) begin
      if ((occ_pop == DEPTH) || dup0) err0 = 1'b1;
      else                            acc0 = 1'b1;
    end
    occ0 = occ_pop + (PW+1)'(acc0);

    acc1 = 1'b0;
    err1 = 1'b0;
    if (fl.free1_en_i && (fl.free1_reg_i != '0)) begin
      if ((occ0 == DEPTH) || dup1) err1 = 1'b1;
      else                         acc1 = 1'b1;
    end

    fifo_d = fifo_q;
    if (acc0) fifo_d[tail_q] = fl.free0_reg_i;
    if (acc1) fifo_d[acc0 ? tail_p1 : tail_q] = fl.free1_reg_i;

    head_d  = head_q + PW'(n_alloc);
    tail_d  = tail_q + PW'(acc0) + PW'(acc1);
    count_d = occ0 + (PW+1)'(acc1);
    error_d = error_q | err0 | err1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_P_REGS; i++) begin
        fifo_q[i] <= (i < INIT_FREE) ? PW'(NUM_A_REGS + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= PW'(INIT_FREE);
      count_q <= (PW+1)'(INIT_FREE);
      error_q <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_P_REGS-1:0] is_free_q, is_free_d;

  // Lookups use the pre-edge vector: a tag popped this cycle still counts as free.
  assign dup0 = is_free_q[fl.free0_reg_i];
  assign dup1 = is_free_q[fl.free1_reg_i] ||
                (fl.free0_en_i && (fl.free1_reg_i == fl.free0_reg_i));

  always_comb begin
    is_free_d = is_free_q;
    if (n_alloc != 2'd0) is_free_d[fifo_q[head_q]]  = 1'b0;
    if (n_alloc == 2'd2) is_free_d[fifo_q[head_p1]] = 1'b0;
    if (acc0)            is_free_d[fl.free0_reg_i]  = 1'b1;
    if (acc1)            is_free_d[fl.free1_reg_i]  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_P_REGS; i++) begin
        is_free_q[i] <= (i >= NUM_A_REGS);
      end
    end else begin
      is_free_q <= is_free_d;
    end
  end
`else
  assign dup0 = 1'b0;
  assign dup1 = 1'b0;
`endif

endmodule

// File: tb/tb_rename_free_list.sv
// Randomized + directed bench for rename_free_list against a queue-based free-list model.
// Honours FREE_LIST_CHECK_EN the same way as the design.
module tb_rename_free_list;
  localparam int NP = 64;
  localparam int NA = 32;
  localparam int PW = 6;
`ifdef FREE_LIST_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_free_list_if #(.NUM_P_REGS(NP)) fl_if ();

  rename_free_list #(.NUM_P_REGS(NP), .NUM_A_REGS(NA)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .fl      (fl_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: free tags in allocation order, tags currently held by the machine.
  int q[$];
  int outst[$];
  bit is_free[NP];
  bit m_err;
  bit a0, a1, f0e, f1e;
  int f0r, f1r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    outst.delete();
    for (int i = 0; i < NP - NA; i++) q.push_back(NA + i);
    for (int i = 0; i < NP; i++) is_free[i] = (i >= NA);
    for (int i = 1; i < NA; i++) outst.push_back(i);
    m_err = 1'b0;
  endfunction

  function automatic void m_push(input int t);
    q.push_back(t);
    is_free[t] = 1'b1;
    for (int i = 0; i < outst.size(); i++) begin
      if (outst[i] == t) begin
        outst.delete(i);
        break;
      end
    end
  endfunction

  function automatic void model_step();
    bit pre[NP];
    int n;
    int t;
    pre = is_free;
    n = (q.size() < 2) ? 0 : (int'(a0) + int'(a1));
    for (int i = 0; i < n; i++) begin
      t = q.pop_front();
      is_free[t] = 1'b0;
      outst.push_back(t);
    end
    if (f0e && f0r != 0) begin
      if (q.size() >= NP)          m_err = 1'b1;
      else if (CHK_EN && pre[f0r]) m_err = 1'b1;
      else                         m_push(f0r);
    end
    if (f1e && f1r != 0) begin
      if (q.size() >= NP)                                  m_err = 1'b1;
      else if (CHK_EN && (pre[f1r] || (f0e && f1r == f0r))) m_err = 1'b1;
      else                                                 m_push(f1r);
    end
  endfunction

  task automatic set_in(input bit i_a0, input bit i_a1, input bit i_f0e, input int i_f0r,
                        input bit i_f1e, input int i_f1r);
    logic [31:0] r0, r1;
    a0 = i_a0; a1 = i_a1; f0e = i_f0e; f0r = i_f0r; f1e = i_f1e; f1r = i_f1r;
    r0 = i_f0r;
    r1 = i_f1r;
    fl_if.alloc0_req_i = i_a0;
    fl_if.alloc1_req_i = i_a1;
    fl_if.free0_en_i   = i_f0e;
    fl_if.free0_reg_i  = r0[PW-1:0];
    fl_if.free1_en_i   = i_f1e;
    fl_if.free1_reg_i  = r1[PW-1:0];
  endtask

  task automatic compare_outputs();
    int sz;
    sz = q.size();
    chk("count", fl_if.free_count_o, sz);
    chk("stall", fl_if.alloc_stall_o, 32'(sz < 2));
    chk("error", fl_if.error_o, m_err);
    if (sz >= 1) chk("dest0", fl_if.alloc_dest0_o, q[0]);
    if (a0 ? (sz >= 2) : (sz >= 1)) chk("dest1", fl_if.alloc_dest1_o, a0 ? q[1] : q[0]);
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input bit i_a0, input bit i_a1, input bit i_f0e, input int i_f0r,
                       input bit i_f1e, input int i_f1r);
    set_in(i_a0, i_a1, i_f0e, i_f0r, i_f1e, i_f1r);
    step();
  endtask

  task automatic do_reset(input int skew);
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    if (skew > 0) #(skew);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_outputs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_tag();
    if (outst.size() > 0 && $urandom_range(0, 3) != 0)
      return outst[$urandom_range(0, outst.size() - 1)];
    return $urandom_range(0, NP - 1);
  endfunction

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

    // Reset values
    do_reset(0);
    chk("t1_count", fl_if.free_count_o, 32);
    chk("t1_dest0", fl_if.alloc_dest0_o, 32);
    chk("t1_dest1", fl_if.alloc_dest1_o, 32);
    chk("t1_stall", fl_if.alloc_stall_o, 0);
    chk("t1_error", fl_if.error_o, 0);

    // Dual allocation
    set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t2_dest0", fl_if.alloc_dest0_o, 32);
    chk("t2_dest1", fl_if.alloc_dest1_o, 33);
    step();
    #1;
    chk("t2_next_dest0", fl_if.alloc_dest0_o, 34);
    chk("t2_next_dest1", fl_if.alloc_dest1_o, 35);
    chk("t2_count", fl_if.free_count_o, 30);

    // Slot-1-only allocation takes the head tag
    do_reset(0);
    set_in(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t3_dest1", fl_if.alloc_dest1_o, 32);
    step();
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t3_dest0", fl_if.alloc_dest0_o, 33);
    chk("t3_count", fl_if.free_count_o, 31);

    // Drain to empty; stall blocks further pops
    do_reset(0);
    repeat (15) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("t4_count2", fl_if.free_count_o, 2);
    chk("t4_nostall", fl_if.alloc_stall_o, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("t4_count0", fl_if.free_count_o, 0);
    chk("t4_stall", fl_if.alloc_stall_o, 1);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("t4_still0", fl_if.free_count_o, 0);

    // Release order, p0 drop, count==1 stall
    cycle(1'b0, 1'b0, 1'b1, 5, 1'b1, 7);
    chk("t5_count2", fl_if.free_count_o, 2);
    set_in(1'b1, 1'b1, 1'b1, 0, 1'b0, 0);
    #1;
    chk("t5_dest0", fl_if.alloc_dest0_o, 5);
    chk("t5_dest1", fl_if.alloc_dest1_o, 7);
    step();
    chk("t5_count0", fl_if.free_count_o, 0);
    cycle(1'b0, 1'b0, 1'b1, 0, 1'b1, 0);
    chk("t5_p0_drop", fl_if.free_count_o, 0);
    cycle(1'b0, 1'b0, 1'b1, 9, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk("t5_one_held", fl_if.free_count_o, 1);
    chk("t5_err_clean", fl_if.error_o, 0);

`ifdef FREE_LIST_CHECK_EN
    // Double free of the same tag in one cycle
    do_reset(0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("t6_count22", fl_if.free_count_o, 22);
    cycle(1'b0, 1'b0, 1'b1, 40, 1'b1, 40);
    chk("t6_count23", fl_if.free_count_o, 23);
    chk("t6_error", fl_if.error_o, 1);
    cycle(1'b0, 1'b0, 1'b1, 40, 1'b0, 0);
    chk("t6_refree", fl_if.free_count_o, 23);
`else
    // Overflow via unchecked duplicates
    do_reset(0);
    for (int k = 1; k < 30; k += 2) cycle(1'b0, 1'b0, 1'b1, k, 1'b1, k + 1);
    cycle(1'b0, 1'b0, 1'b1, 31, 1'b0, 0);
    chk("t6_count63", fl_if.free_count_o, 63);
    chk("t6_noerr", fl_if.error_o, 0);
    cycle(1'b0, 1'b0, 1'b1, 1, 1'b1, 2);
    chk("t6_count64", fl_if.free_count_o, 64);
    chk("t6_ovf_err", fl_if.error_o, 1);
`endif

    // Random traffic with periodic mid-run resets
    do_reset(0);
    for (int c = 0; c < 2400; c++) begin
      if (c % 400 == 399) begin
        do_reset($urandom_range(0, 3));
      end else begin
        cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 5, pick_tag(),
              $urandom_range(0, 9) < 5, pick_tag());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
